text_console_ctrl: RTL and testbench



---
 rtl/console_pkg.sv | 23 ++
 rtl/console_cursor.sv | 81 ++++++++
 rtl/text_console_ctrl.sv | 154 +++++++++++++++
 tb/tb_text_console_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/console_pkg.sv
// Shared constants and state type for the text console write controller.
package console_pkg;

  localparam int COLS_DEF = 107;
  localparam int ROWS_DEF = 40;

  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SPACE = 8'h20;

  typedef enum logic [1:0] {
    CLR_SCREEN = 2'd0,
    IDLE       = 2'd1,
    CLR_LINE   = 2'd2
  } console_state_e;

  function automatic logic is_ctrl(input logic [7:0] c);
    return (c == CH_BS) || (c == CH_LF) || (c == CH_FF) || (c == CH_CR);
  endfunction

endpackage

// File: rtl/console_cursor.sv
// Cursor position and row base address; row_base tracks row*COLS by addition only.
module console_cursor
  import console_pkg::*;
#(
  parameter int COLS   = COLS_DEF,
  parameter int ROWS   = ROWS_DEF,
  parameter int ADDR_W = 13
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              inc_i,
  input  logic              cr_i,
  input  logic              lf_i,
  input  logic              back_i,
  input  logic              home_i,
  output logic [6:0]        col_o,
  output logic [5:0]        row_o,
  output logic [ADDR_W-1:0] row_base_o,
  output logic [ADDR_W-1:0] cell_addr_o,
  output logic              last_col_o,
  output logic              first_col_o
);

  logic [6:0]        col_q, col_d;
  logic [5:0]        row_q, row_d;
  logic [ADDR_W-1:0] rb_q, rb_d;
  logic              last_col;
  logic              first_col;
  logic              advance;

  assign last_col  = (col_q == 7'(COLS - 1));
  assign first_col = (col_q == 7'd0);
  // A printable in the last column behaves like a newline after its write.
  assign advance   = lf_i || (inc_i && last_col);

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    rb_d  = rb_q;
    if (home_i) begin
      col_d = 7'd0;
      row_d = 6'd0;
      rb_d  = '0;
    end else if (advance) begin
      col_d = 7'd0;
      if (row_q == 6'(ROWS - 1)) begin
        row_d = 6'd0;
        rb_d  = '0;
      end else begin
        row_d = row_q + 6'd1;
        rb_d  = rb_q + ADDR_W'(COLS);
      end
    end else if (inc_i) begin
      col_d = col_q + 7'd1;
    end else if (cr_i) begin
      col_d = 7'd0;
    end else if (back_i && !first_col) begin
      col_d = col_q - 7'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      col_q <= 7'd0;
      row_q <= 6'd0;
      rb_q  <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      rb_q  <= rb_d;
    end
  end

  assign col_o       = col_q;
  assign row_o       = row_q;
  assign row_base_o  = rb_q;
  assign cell_addr_o = rb_q + ADDR_W'(col_q);
  assign last_col_o  = last_col;
  assign first_col_o = first_col;

endmodule

// File: rtl/text_console_ctrl.sv
// Byte-stream terminal controller driving the character video memory write port.
module text_console_ctrl
  import console_pkg::*;
#(
  parameter int COLS   = COLS_DEF,
  parameter int ROWS   = ROWS_DEF,
  parameter int ADDR_W = 13
) (
  input  logic              write_clk,
  input  logic              write_rst_n,
  input  logic [7:0]        in_char,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [7:0]        vm_ch_in,
  output logic [ADDR_W-1:0] vm_ch_addr,
  output logic              vm_ch_write_enable,
  output logic [6:0]        cursor_col,
  output logic [5:0]        cursor_row,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  localparam int               CNT_W      = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LINE_LEN   = CNT_W'(COLS);
  localparam logic [CNT_W-1:0] SCREEN_LEN = CNT_W'(COLS * ROWS);

  console_state_e    state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              ready_q;
  logic              busy_q;
  logic              we_q;
  logic [7:0]        data_q;
  logic [ADDR_W-1:0] addr_q;

  logic              accept;
  logic              is_cr, is_lf, is_bs, is_ff, is_print;
  logic [ADDR_W-1:0] row_base;
  logic [ADDR_W-1:0] cell_addr;
  logic              last_col;
  logic              first_col;

  // Handshake: a byte transfers on a rising edge where in_valid && in_ready;
  // in_ready is high only in IDLE, and the producer holds in_char until then.
  assign accept   = in_valid && ready_q;
  assign is_cr    = (in_char == CH_CR);
  assign is_lf    = (in_char == CH_LF);
  assign is_bs    = (in_char == CH_BS);
  assign is_ff    = (in_char == CH_FF);
  assign is_print = !is_ctrl(in_char);

  console_cursor #(
    .COLS   (COLS),
    .ROWS   (ROWS),
    .ADDR_W (ADDR_W)
  ) u_cursor (
    .clk_i       (write_clk),
    .rst_ni      (write_rst_n),
    .inc_i       (accept && is_print),
    .cr_i        (accept && is_cr),
    .lf_i        (accept && is_lf),
    .back_i      (accept && is_bs),
    .home_i      (accept && is_ff),
    .col_o       (cursor_col),
    .row_o       (cursor_row),
    .row_base_o  (row_base),
    .cell_addr_o (cell_addr),
    .last_col_o  (last_col),
    .first_col_o (first_col)
  );

  always_ff @(posedge write_clk or negedge write_rst_n) begin
    if (!write_rst_n) begin
      state_q <= CLR_SCREEN;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b1;
      we_q    <= 1'b0;
      data_q  <= CH_SPACE;
      addr_q  <= '0;
    end else begin
      we_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (is_print) begin
              we_q   <= 1'b1;
              data_q <= in_char;
              addr_q <= cell_addr;
              if (last_col) begin
                state_q <= CLR_LINE;
                cnt_q   <= '0;
                ready_q <= 1'b0;
                busy_q  <= 1'b1;
              end
            end else if (is_lf) begin
              state_q <= CLR_LINE;
              cnt_q   <= '0;
              ready_q <= 1'b0;
              busy_q  <= 1'b1;
            end else if (is_ff) begin
              state_q <= CLR_SCREEN;
              cnt_q   <= '0;
              ready_q <= 1'b0;
              busy_q  <= 1'b1;
            end else if (is_bs && !first_col) begin
              we_q   <= 1'b1;
              data_q <= CH_SPACE;
              addr_q <= cell_addr - ADDR_W'(1);
            end
          end
        end
        // row_base already points at the new row when the line clear starts.
        CLR_LINE: begin
          if (cnt_q == LINE_LEN) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            we_q   <= 1'b1;
            data_q <= CH_SPACE;
            addr_q <= row_base + ADDR_W'(cnt_q);
            cnt_q  <= cnt_q + CNT_W'(1);
          end
        end
        CLR_SCREEN: begin
          if (cnt_q == SCREEN_LEN) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            we_q   <= 1'b1;
            data_q <= CH_SPACE;
            addr_q <= cnt_q[ADDR_W-1:0];
            cnt_q  <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= CLR_SCREEN;
          cnt_q   <= '0;
          ready_q <= 1'b0;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready           = ready_q;
  assign busy               = busy_q;
  assign vm_ch_write_enable = we_q;
  assign vm_ch_in           = data_q;
  assign vm_ch_addr         = addr_q;
  assign dbg_state          = state_q;

endmodule

// File: tb/tb_text_console_ctrl.sv
// Randomized bench for text_console_ctrl against a row/col screen model.
module tb_text_console_ctrl;

  localparam int COLS   = 107;
  localparam int ROWS   = 40;
  localparam int ADDR_W = 13;
  localparam int CELLS  = COLS * ROWS;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [7:0]        in_char = 8'h00;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [7:0]        vm_ch_in;
  logic [ADDR_W-1:0] vm_ch_addr;
  logic              vm_ch_write_enable;
  logic [6:0]        cursor_col;
  logic [5:0]        cursor_row;
  logic              busy;
  logic [1:0]        dbg_state;

  text_console_ctrl #(
    .COLS   (COLS),
    .ROWS   (ROWS),
    .ADDR_W (ADDR_W)
  ) dut (
    .write_clk          (clk),
    .write_rst_n        (rst_n),
    .in_char            (in_char),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .vm_ch_in           (vm_ch_in),
    .vm_ch_addr         (vm_ch_addr),
    .vm_ch_write_enable (vm_ch_write_enable),
    .cursor_col         (cursor_col),
    .cursor_row         (cursor_row),
    .busy               (busy),
    .dbg_state          (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int m_row = 0;
  int m_col = 0;
  logic [ADDR_W+7:0] exp_q[$];

  function automatic void push_wr(input int addr, input logic [7:0] d);
    exp_q.push_back({ADDR_W'(addr), d});
  endfunction

  function automatic void model_newline();
    m_col = 0;
    m_row = (m_row + 1) % ROWS;
    for (int i = 0; i < COLS; i++) push_wr(m_row * COLS + i, 8'h20);
  endfunction

  function automatic void model_screen_clear();
    m_row = 0;
    m_col = 0;
    for (int i = 0; i < CELLS; i++) push_wr(i, 8'h20);
  endfunction

  function automatic void model_accept(input logic [7:0] c);
    case (c)
      8'h0D: m_col = 0;
      8'h0A: model_newline();
      8'h08: begin
        if (m_col > 0) begin
          m_col--;
          push_wr(m_row * COLS + m_col, 8'h20);
        end
      end
      8'h0C: model_screen_clear();
      default: begin
        push_wr(m_row * COLS + m_col, c);
        if (m_col == COLS - 1) model_newline();
        else m_col++;
      end
    endcase
  endfunction

  function automatic logic [7:0] rand_print();
    logic [7:0] c;
    do c = 8'($urandom_range(0, 255));
    while (c == 8'h0D || c == 8'h0A || c == 8'h08 || c == 8'h0C);
    return c;
  endfunction

  // ---------------- scoreboard / monitor ----------------
  int                wr_count = 0;
  int                last_wr_cyc = 0;
  int                prev_wr_cyc = 0;
  logic [ADDR_W-1:0] last_wr_addr = '0;

  always @(negedge clk) begin
    logic [ADDR_W+7:0] e;
    if (rst_n) begin
      check("busy_inv", busy, !in_ready);
      if (vm_ch_write_enable) begin
        wr_count++;
        prev_wr_cyc  = last_wr_cyc;
        last_wr_cyc  = cyc;
        last_wr_addr = vm_ch_addr;
        check("wr_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("wr_addr", vm_ch_addr, e[ADDR_W+7:8]);
          check("wr_data", vm_ch_in, e[7:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_cursor(input int row, input int col);
    check("cur_row", cursor_row, row);
    check("cur_col", cursor_col, col);
  endtask

  task automatic check_reset_vals();
    check("rst_we", vm_ch_write_enable, 0);
    check("rst_addr", vm_ch_addr, 0);
    check("rst_data", vm_ch_in, 8'h20);
    check("rst_ready", in_ready, 0);
    check("rst_busy", busy, 1);
    check_cursor(0, 0);
  endtask

  task automatic send(input logic [7:0] c);
    int n;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("send_ready", in_ready, 1);
    if (in_ready) begin
      check_cursor(m_row, m_col);
      in_char  = c;
      in_valid = 1'b1;
      @(posedge clk);
      model_accept(c);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("idle_ready", in_ready, 1);
    #1;
    check("drain", exp_q.size(), 0);
    check_cursor(m_row, m_col);
  endtask

  // Releases reset and checks the full-screen clear timing from edge 0.
  task automatic release_reset();
    int c;
    int nwr;
    exp_q.delete();
    model_screen_clear();
    @(negedge clk);
    rst_n = 1'b1;
    c = 0;
    nwr = 0;
    do begin
      @(negedge clk);
      c++;
      if (vm_ch_write_enable) nwr++;
    end while (!in_ready && c < 20000);
    check("clr_ready_cyc", c, CELLS + 1);
    check("clr_wr_cnt", nwr, CELLS);
    #1;
    check("clr_drain", exp_q.size(), 0);
    check_cursor(0, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int w0;
    int base;
    logic [7:0] c;

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals();
    release_reset();

    // back-to-back "AB"
    @(negedge clk);
    in_char  = 8'h41;
    in_valid = 1'b1;
    @(posedge clk);
    model_accept(8'h41);
    @(negedge clk);
    check("ab_ready", in_ready, 1);
    in_char = 8'h42;
    @(posedge clk);
    model_accept(8'h42);
    #1 in_valid = 1'b0;
    @(negedge clk);
    #1;
    check("ab_consec", last_wr_cyc - prev_wr_cyc, 1);
    check("ab_ready2", in_ready, 1);
    check_cursor(0, 2);
    wait_idle();

    // printable in last column of row 3
    repeat (3) send(8'h0A);
    repeat (106) send(rand_print());
    wait_idle();
    check_cursor(3, 106);
    send(8'h5A);
    n = 0;
    do begin
      @(negedge clk);
      if (!in_ready) n++;
    end while (!in_ready && n < 20000);
    check("wrap_lowcyc", n, COLS + 1);
    #1;
    check("wrap_drain", exp_q.size(), 0);
    check_cursor(4, 0);

    // LF from the last row wraps to row 0
    repeat (35) send(8'h0A);
    repeat (5) send(rand_print());
    wait_idle();
    check_cursor(39, 5);
    send(8'h0A);
    wait_idle();
    check_cursor(0, 0);
    check("lf_last_addr", last_wr_addr, COLS - 1);

    // backspace at column 0 and column 10
    send(8'h0A);
    send(8'h0A);
    wait_idle();
    w0 = wr_count;
    send(8'h08);
    repeat (3) @(negedge clk);
    #1;
    check("bs0_nowr", wr_count, w0);
    check_cursor(2, 0);
    repeat (10) send(rand_print());
    wait_idle();
    w0 = wr_count;
    send(8'h08);
    @(negedge clk);
    #1;
    check("bs_wr", wr_count, w0 + 1);
    check("bs_addr", last_wr_addr, 223);
    check_cursor(2, 9);

    // randomized stream
    for (int i = 0; i < 400; i++) begin
      n = $urandom_range(0, 99);
      if (n < 5) c = 8'h0A;
      else if (n < 10) c = 8'h0D;
      else if (n < 20) c = 8'h08;
      else c = rand_print();
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      send(c);
    end
    wait_idle();

    // form feed, then reset part way through the clear
    send(rand_print());
    send(rand_print());
    send(8'h0C);
    base = wr_count;
    n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while (wr_count - base < 100 && n < 20000);
    check("ff_partial", wr_count - base, 100);
    rst_n = 1'b0;
    #1;
    check_reset_vals();
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals();
    release_reset();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
